// File: rtl/down_counter_reload.sv
// Loadable down-counter/timer with one-shot (stop at zero) and periodic (auto-reload) modes.
// count/tc registered; tc is a single-cycle pulse on the enabled cycle that reaches terminal count.
module down_counter_reload #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] reload_val;
  logic             mode_q;

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      tc         <= 1'b0;
      reload_val <= '0;
      mode_q     <= 1'b0;
      state      <= IDLE;
    end else begin
      tc <= 1'b0;
      if (clr) begin
        count <= '0;
        state <= IDLE;
      end else if (load) begin
        reload_val <= load_val;
        mode_q     <= mode;
        count      <= load_val;
        state      <= (load_val != '0) ? RUN : IDLE;
      end else if (state == RUN && en) begin
        // RUN never holds 0: a zero load goes to IDLE and reload_val is non-zero here
        if (count > ONE) begin
          count <= count - ONE;
        end else begin
          tc <= 1'b1;
          if (mode_q) begin
            count <= reload_val;
          end else begin
            count <= '0;
            state <= DONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_down_counter_reload.sv
// Directed bench for down_counter_reload: reset, one-shot, periodic, enable gating,
// mid-run load/clr and asynchronous reset, with hand-computed expectations.
module tb_down_counter_reload;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       load;
  logic [3:0] load_val;
  logic       mode;
  logic       en;
  logic [3:0] count;
  logic       tc;
  logic       busy;

  int n_pass = 0;
  int n_total = 0;

  down_counter_reload #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .mode(mode), .en(en), .count(count), .tc(tc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk(input string tag, input int c, input int t, input int b);
    chk1({tag, ".count"}, {28'b0, count}, c);
    chk1({tag, ".tc"},    {31'b0, tc},    t);
    chk1({tag, ".busy"},  {31'b0, busy},  b);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; clr = 1'b0; load = 1'b1; load_val = 4'd5; mode = 1'b0; en = 1'b1;
    #1;
    chk("reset0", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_hold", 0, 0, 0);
    end
    load = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_reset_idle", 0, 0, 0);
    end

    // one-shot 3
    load = 1'b1; load_val = 4'd3; mode = 1'b0; en = 1'b1;
    step(); chk("os_load", 3, 0, 1);
    load = 1'b0; mode = 1'b1;
    step(); chk("os_2", 2, 0, 1);
    step(); chk("os_1", 1, 0, 1);
    step(); chk("os_0", 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("os_hold", 0, 0, 0);
    end

    // periodic 2
    load = 1'b1; load_val = 4'd2; mode = 1'b1;
    step(); chk("per2_load", 2, 0, 1);
    load = 1'b0; mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk("per2_1", 1, 0, 1);
      step(); chk("per2_2", 2, 1, 1);
    end

    // periodic 1
    load = 1'b1; load_val = 4'd1; mode = 1'b1;
    step(); chk("per1_load", 1, 0, 1);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); chk("per1", 1, 1, 1);
    end

    // enable gating
    load = 1'b1; load_val = 4'd4; mode = 1'b0;
    step(); chk("en_load", 4, 0, 1);
    load = 1'b0;
    en = 1'b1; step(); chk("en_a", 3, 0, 1);
    en = 1'b0; step(); chk("en_b", 3, 0, 1);
    en = 1'b0; step(); chk("en_c", 3, 0, 1);
    en = 1'b1; step(); chk("en_d", 2, 0, 1);
    en = 1'b1; step(); chk("en_e", 1, 0, 1);
    en = 1'b0; step(); chk("en_f", 1, 0, 1);
    en = 1'b1; step(); chk("en_g", 0, 1, 0);
    step(); chk("en_done", 0, 0, 0);

    // mid-run reload
    load = 1'b1; load_val = 4'd15; mode = 1'b0; en = 1'b1;
    step(); chk("mid_load15", 15, 0, 1);
    load = 1'b0;
    step(); chk("mid_14", 14, 0, 1);
    step(); chk("mid_13", 13, 0, 1);
    step(); chk("mid_12", 12, 0, 1);
    load = 1'b1; load_val = 4'd5;
    step(); chk("mid_reload5", 5, 0, 1);
    load = 1'b0;
    step(); chk("mid_4", 4, 0, 1);
    step(); chk("mid_3", 3, 0, 1);
    clr = 1'b1;
    step(); chk("mid_clr", 0, 0, 0);
    clr = 1'b0;
    step(); chk("mid_after_clr", 0, 0, 0);
    load = 1'b1; load_val = 4'd0;
    step(); chk("load0", 0, 0, 0);
    load = 1'b0;
    step(); chk("load0_idle", 0, 0, 0);
    step(); chk("load0_idle2", 0, 0, 0);
    load = 1'b1; load_val = 4'd7;
    step(); chk("pre_clr_load", 7, 0, 1);
    clr = 1'b1; load = 1'b1; load_val = 4'd9;
    step(); chk("clr_beats_load", 0, 0, 0);
    clr = 1'b0; load = 1'b0;
    step(); chk("clr_beats_load_idle", 0, 0, 0);

    // async reset mid-run
    load = 1'b1; load_val = 4'd9; mode = 1'b1; en = 1'b1;
    step(); chk("ar_load9", 9, 0, 1);
    load = 1'b0;
    step(); chk("ar_8", 8, 0, 1);
    step(); chk("ar_7", 7, 0, 1);
    step(); chk("ar_6", 6, 0, 1);
    #2 rst = 1'b0;
    #1 chk("ar_async", 0, 0, 0);
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); chk("ar_idle", 0, 0, 0);
    end
    load = 1'b1; load_val = 4'd2; mode = 1'b0;
    step(); chk("ar_reload", 2, 0, 1);
    load = 1'b0;
    step(); chk("ar_reload_1", 1, 0, 1);
    step(); chk("ar_reload_0", 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
